// File: rtl/ex_muldiv.sv
// Multi-cycle M-extension execute unit: bit-serial shift-add multiply and
// restoring divide, one bit per cycle, with pipeline stall and flush.
module ex_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            rd_wen_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o
);

  localparam int W2 = 2 * XLEN;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_REM    = 3'b110;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic              busy_q;
  logic [2:0]        f3_q;
  logic [4:0]        rd_addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              s1_q;
  logic              s2_q;
  logic [XLEN-1:0]   a_q;
  logic [W2-1:0]     acc_q;
  logic [4:0]        res_addr_q;
  logic [XLEN-1:0]   res_data_q;

  // Request decode (operand magnitudes, sign flags, preset results).
  logic              is_div;
  logic              sgn1;
  logic              sgn2;
  logic              neg1;
  logic              neg2;
  logic [XLEN-1:0]   mag1;
  logic [XLEN-1:0]   mag2;
  logic              div_zero;
  logic              div_ovf;
  logic [XLEN-1:0]   special_res;

  always_comb begin
    is_div   = funct3_i[2];
    sgn1     = (funct3_i == F_MULH) || (funct3_i == F_MULHSU) ||
               (funct3_i == F_DIV)  || (funct3_i == F_REM);
    sgn2     = (funct3_i == F_MULH) || (funct3_i == F_DIV) || (funct3_i == F_REM);
    neg1     = sgn1 && op1_i[XLEN-1];
    neg2     = sgn2 && op2_i[XLEN-1];
    mag1     = neg1 ? -op1_i : op1_i;
    mag2     = neg2 ? -op2_i : op2_i;
    div_zero = is_div && (op2_i == '0);
    div_ovf  = ((funct3_i == F_DIV) || (funct3_i == F_REM)) &&
               (op1_i == INT_MIN) && (op2_i == '1);
    if (div_zero) begin
      special_res = funct3_i[1] ? op1_i : '1;
    end else begin
      special_res = funct3_i[1] ? '0 : op1_i;
    end
  end

  // One iteration step; acc_q holds {high, low} for both multiply and divide.
  logic [XLEN:0]     mul_sum;
  logic [W2-1:0]     mul_nx;
  logic [W2:0]       div_sh;
  logic [XLEN:0]     div_trial;
  logic [W2-1:0]     div_nx;
  logic [W2-1:0]     acc_d;
  logic [W2-1:0]     prod;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   div_res;
  logic [XLEN-1:0]   result_d;
  logic [CNT_W-1:0]  cnt_d;

  always_comb begin
    mul_sum   = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_nx    = {mul_sum, acc_q[XLEN-1:1]};
    div_sh    = {acc_q, 1'b0};
    div_trial = div_sh[W2:XLEN] - {1'b0, a_q};
    // A borrow out of the trial subtraction means the divisor did not fit.
    div_nx    = div_trial[XLEN] ? div_sh[W2-1:0]
                                : {div_trial[XLEN-1:0], div_sh[XLEN-1:1], 1'b1};
    acc_d     = f3_q[2] ? div_nx : mul_nx;

    prod      = (s1_q ^ s2_q) ? -acc_d : acc_d;
    mul_res   = (f3_q == F_MUL) ? prod[XLEN-1:0] : prod[W2-1:XLEN];
    quo       = acc_d[XLEN-1:0];
    rem       = acc_d[W2-1:XLEN];
    div_res   = f3_q[1] ? (s1_q ? -rem : rem)
                        : ((s1_q ^ s2_q) ? -quo : quo);
    result_d  = f3_q[2] ? div_res : mul_res;
    cnt_d     = cnt_q - CNT_W'(1);
  end

  // Handshake: a request is taken when start_i is high in IDLE with flush_i low;
  // stall_o holds the pipeline from that cycle through the last CALC cycle, and
  // the result is presented for exactly one cycle with done_o = rd_wen_o = 1.
  assign stall_o   = ((state_q == S_IDLE) && start_i && !flush_i) || (state_q == S_CALC);
  assign done_o    = (state_q == S_DONE) && !flush_i;
  assign rd_wen_o  = done_o;
  assign busy_o    = busy_q;
  assign rd_addr_o = res_addr_q;
  assign rd_data_o = res_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      f3_q       <= '0;
      rd_addr_q  <= '0;
      cnt_q      <= '0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      a_q        <= '0;
      acc_q      <= '0;
      res_addr_q <= '0;
      res_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i && !flush_i) begin
            f3_q      <= funct3_i;
            rd_addr_q <= rd_addr_i;
            busy_q    <= 1'b1;
            if (div_zero || div_ovf) begin
              res_data_q <= special_res;
              res_addr_q <= rd_addr_i;
              state_q    <= S_DONE;
            end else begin
              s1_q    <= neg1;
              s2_q    <= neg2;
              // Multiply: a_q is the multiplicand, low half the multiplier.
              // Divide: a_q is the divisor, low half the dividend.
              a_q     <= is_div ? mag2 : mag1;
              acc_q   <= {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
              cnt_q   <= CNT_W'(XLEN);
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (cnt_q == CNT_W'(1)) begin
              res_data_q <= result_d;
              res_addr_q <= rd_addr_q;
              state_q    <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: vector table, flush/reset sequences and a
// continuously-held start_i stream checked against a reference model.
module tb_ex_muldiv;

  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 1;
  localparam int NV   = 20;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] op1_i;
  logic [XLEN-1:0] op2_i;
  logic [4:0]      rd_addr_i;
  logic            flush_i;
  logic            stall_o;
  logic            busy_o;
  logic            done_o;
  logic            rd_wen_o;
  logic [4:0]      rd_addr_o;
  logic [XLEN-1:0] rd_data_o;

  ex_muldiv #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .funct3_i  (funct3_i),
    .op1_i     (op1_i),
    .op2_i     (op2_i),
    .rd_addr_i (rd_addr_i),
    .flush_i   (flush_i),
    .stall_o   (stall_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .rd_wen_o  (rd_wen_o),
    .rd_addr_o (rd_addr_o),
    .rd_data_o (rd_data_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  logic [XLEN+4:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Scoreboard: every done_o must match the oldest expected {rd_addr, rd_data}.
  always @(negedge clk) begin
    if (done_o === 1'b1) begin
      logic [XLEN+4:0] e;
      done_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: rd=%0d data=%h with nothing expected", rd_addr_o, rd_data_o);
      end else begin
        e = exp_q.pop_front();
        if ({rd_addr_o, rd_data_o} !== e || rd_wen_o !== 1'b1) begin
          errors++;
          $display("FAIL result: got rd=%0d data=%h wen=%b, expected rd=%0d data=%h wen=1",
                   rd_addr_o, rd_data_o, rd_wen_o, e[XLEN+4:XLEN], e[XLEN-1:0]);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    p  = '0;
    r  = '0;
    case (f)
      3'd0: begin p = 64'(ua * ub); r = p[31:0];  end
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
      3'd3: begin p = 64'(ua * ub); r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF :
                ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb));
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a :
                ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat, output int stall_n,
                        output int busy_n);
    bit seen;
    @(posedge clk); #1;
    start_i = 1'b1; funct3_i = f; op1_i = a; op2_i = b; rd_addr_i = rd;
    @(negedge clk);
    stall_n = stall_o ? 1 : 0;
    busy_n  = 0;
    @(posedge clk); #1;
    start_i = 1'b0;
    lat  = -1;
    seen = 0;
    for (int k = 1; k <= 100 && !seen; k++) begin
      @(negedge clk);
      if (stall_o) stall_n++;
      if (busy_o) busy_n++;
      if (done_o) begin
        seen = 1;
        lat  = k;
      end
    end
    if (seen) begin
      @(negedge clk);
      check("done_pulse_width", done_o, 1'b0);
    end
  endtask

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    logic        special;
  } vec_t;

  vec_t vecs[NV];

  initial begin
    int lat, stall_n, busy_n, d0;

    vecs[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b0}; // MUL
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000, 1'b0}; // MULH
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 1'b0}; // MULHU
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 1'b0}; // MULHSU
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFD, 1'b0}; // DIV -7/2
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF, 1'b0}; // REM -7/2
    vecs[6]  = '{3'd5, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'h7FFF_FFFC, 1'b0}; // DIVU
    vecs[7]  = '{3'd5, 32'd123,       32'd0,         5'd8,  32'hFFFF_FFFF, 1'b1}; // DIVU /0
    vecs[8]  = '{3'd6, 32'd123,       32'd0,         5'd9,  32'd123,       1'b1}; // REM /0
    vecs[9]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1'b1}; // DIV ovf
    vecs[10] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0,         1'b1}; // REM ovf
    vecs[11] = '{3'd7, 32'd100,       32'd7,         5'd12, 32'd2,         1'b0}; // REMU
    vecs[12] = '{3'd0, 32'h1234_5678, 32'h10,        5'd13, 32'h2345_6780, 1'b0}; // MUL
    vecs[13] = '{3'd1, 32'hFFFF_FFFD, 32'd5,         5'd14, 32'hFFFF_FFFF, 1'b0}; // MULH -3*5
    vecs[14] = '{3'd4, 32'd7,         32'hFFFF_FFFE, 5'd15, 32'hFFFF_FFFD, 1'b0}; // DIV 7/-2
    vecs[15] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 5'd16, 32'd1,         1'b0}; // REM 7/-2
    vecs[16] = '{3'd5, 32'd5,         32'd7,         5'd17, 32'd0,         1'b0}; // DIVU 5/7
    vecs[17] = '{3'd4, 32'h8000_0000, 32'd0,         5'd18, 32'hFFFF_FFFF, 1'b1}; // DIV /0
    vecs[18] = '{3'd3, 32'h8000_0000, 32'd2,         5'd19, 32'd1,         1'b0}; // MULHU
    vecs[19] = '{3'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd20, 32'hFFFF_FFFF, 1'b0}; // REM -7/-2

    rst = 1'b1; start_i = 1'b0; funct3_i = '0; op1_i = '0; op2_i = '0;
    rd_addr_i = '0; flush_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_done",    done_o,    1'b0);
    check("reset_wen",     rd_wen_o,  1'b0);
    check("reset_busy",    busy_o,    1'b0);
    check("reset_stall",   stall_o,   1'b0);
    check("reset_rd_addr", rd_addr_o, 5'd0);
    check("reset_rd_data", rd_data_o, 32'd0);
    rst = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < NV; i++) begin
      exp_q.push_back({vecs[i].rd, vecs[i].exp});
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, lat, stall_n, busy_n);
      check($sformatf("latency_v%0d", i),     lat,     vecs[i].special ? 1 : LAT);
      check($sformatf("stall_cycles_v%0d", i), stall_n, vecs[i].special ? 1 : LAT);
      check($sformatf("busy_cycles_v%0d", i),  busy_n,  vecs[i].special ? 1 : LAT);
    end

    // Flush at the 10th CALC cycle: no completion, previous result held.
    d0 = done_cnt;
    @(posedge clk); #1;
    start_i = 1'b1; funct3_i = 3'd5; op1_i = 32'd1000; op2_i = 32'd3; rd_addr_i = 5'd21;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(negedge clk);
    check("flush_calc_stall", stall_o, 1'b1);
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    check("flush_calc_busy", busy_o, 1'b0);
    check("flush_calc_data_held", rd_data_o, vecs[NV-1].exp);
    repeat (40) @(posedge clk);
    check("flush_calc_no_done", done_cnt - d0, 0);

    exp_q.push_back({5'd22, 32'd14});
    run_op(3'd5, 32'd100, 32'd7, 5'd22, lat, stall_n, busy_n);
    check("after_flush_latency", lat, LAT);

    // Flush in IDLE blocks acceptance.
    @(posedge clk); #1;
    start_i = 1'b1; flush_i = 1'b1; funct3_i = 3'd0; op1_i = 32'd3; op2_i = 32'd3;
    @(negedge clk);
    check("flush_idle_stall", stall_o, 1'b0);
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    check("flush_idle_busy", busy_o, 1'b0);

    // Flush in DONE suppresses done_o in that same cycle.
    d0 = done_cnt;
    @(posedge clk); #1;
    start_i = 1'b1; funct3_i = 3'd5; op1_i = 32'd5; op2_i = 32'd0; rd_addr_i = 5'd23;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b1;
    @(negedge clk);
    check("flush_done_done", done_o,   1'b0);
    check("flush_done_wen",  rd_wen_o, 1'b0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    check("flush_done_busy", busy_o, 1'b0);
    repeat (5) @(posedge clk);
    check("flush_done_no_done", done_cnt - d0, 0);

    // Asynchronous reset in the middle of CALC.
    d0 = done_cnt;
    @(posedge clk); #1;
    start_i = 1'b1; funct3_i = 3'd0; op1_i = 32'd9; op2_i = 32'd9; rd_addr_i = 5'd24;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_async_busy",    busy_o,    1'b0);
    check("rst_async_stall",   stall_o,   1'b0);
    check("rst_async_done",    done_o,    1'b0);
    check("rst_async_rd_addr", rd_addr_o, 5'd0);
    check("rst_async_rd_data", rd_data_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    check("rst_no_done", done_cnt - d0, 0);

    // start_i held high with new operands every cycle: accepted every XLEN+2.
    d0 = done_cnt;
    for (int i = 0; i < 3 * (XLEN + 2); i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      @(posedge clk); #1;
      f = 3'(i + i / (XLEN + 2));
      a = 32'hF000_0000 + 32'(i) * 32'h0012_3457;
      b = 32'h0000_0007 + 32'(i) * 32'h0034_5679;
      start_i = 1'b1; funct3_i = f; op1_i = a; op2_i = b; rd_addr_i = 5'(i);
      if (i % (XLEN + 2) == 0) exp_q.push_back({5'(i), ref_op(f, a, b)});
    end
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (40) @(posedge clk);
    check("held_start_done_count", done_cnt - d0, 3);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Parametrised multi-cycle execute unit for the M extension, sitting beside the single-cycle ALU path in the execute stage. It accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operation, iterates one bit per cycle, and returns a registered result with destination address and write enable. It holds the pipeline through a stall output and can be cancelled with a flush.

## Interface
- XLEN, 32: operand and result width; any value ≥ 8.
- CNT_W, $clog2(XLEN)+1: iteration counter width (derived; do not override).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  operation request; sampled only in IDLE.
- funct3_i  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op1_i  in  XLEN  rs1 value (multiplicand / dividend).
- op2_i  in  XLEN  rs2 value (multiplier / divisor).
- rd_addr_i  in  5  destination register.
- flush_i  in  1  cancel any in-flight operation.
- stall_o  out  1  combinational: (IDLE & start_i & ~flush_i) | CALC.
- busy_o  out  1  registered: high in CALC and DONE.
- done_o  out  1  one-cycle result-valid pulse.
- rd_wen_o  out  1  equals done_o.
- rd_addr_o  out  5  latched rd_addr_i; valid when done_o.
- rd_data_o  out  XLEN  result; valid when done_o.

## Operation
- States: IDLE, CALC, DONE. Reset: IDLE; done_o, rd_wen_o, busy_o = 0; rd_addr_o = 0; rd_data_o = 0; all internal registers = 0.
- IDLE, start_i=1, flush_i=0: latch funct3, rd_addr, operand magnitudes and sign flags.
  - Signedness: MUL/MULH/DIV/REM both operands signed; MULHSU op1 signed, op2 unsigned; MULHU/DIVU/REMU unsigned. MUL sign handling is irrelevant to the low half; treat MUL as unsigned.
  - Special cases, go directly to DONE with a preset result:
    - Divide by zero: quotient = all ones; remainder = op1.
    - Signed overflow, DIV/REM with op1 = 1<<(XLEN-1) and op2 = all ones: quotient = op1; remainder = 0.
  - Otherwise load counter = XLEN and go to CALC.
- CALC: one iteration per cycle; counter decrements each cycle.
  - Multiply: shift-add into a 2·XLEN accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - On the cycle the counter reaches 1, apply the sign fix-up and load rd_data_o, then enter DONE.
    - Product: negate the 2·XLEN product if the operand signs differ. MUL takes the low half; the others take the high half.
    - Quotient: negate if signs differ. Remainder: takes the sign of the dividend.
- DONE: done_o = rd_wen_o = 1 for exactly this cycle, then return to IDLE. start_i is ignored in DONE and CALC. rd_data_o and rd_addr_o hold until the next completion.
- flush_i in any state: the next edge forces IDLE with done_o = 0. flush_i in DONE suppresses done_o in that same cycle (done_o is gated combinationally by ~flush_i). flush_i in IDLE blocks acceptance.
- rst asserted mid-operation returns immediately to reset values; no done_o follows.
- All arithmetic is modulo 2^XLEN (2^(2·XLEN) for the product). No exceptions are raised.

## Timing
- Start accepted at edge T (IDLE, start_i=1).
- Normal operation: CALC occupies cycles T+1 … T+XLEN; done_o is high in cycle T+XLEN+1. Total latency XLEN+1 cycles (33 at XLEN=32).
- Special case: done_o is high in cycle T+1.
- Earliest next acceptance: the cycle after done_o. Throughput is one op per XLEN+2 cycles.
- stall_o is high from the request cycle through the last CALC cycle. It is low in the DONE cycle, so the pipeline advances with the result.

## Test plan
- MUL: op1 = 7, op2 = 0xFFFFFFFD, rd = 5 → done_o exactly 33 cycles after acceptance, rd_data_o = 0xFFFFFFEB, rd_addr_o = 5, stall_o high for 33 cycles.
- High halves:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Signed division: DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC.
- Special cases, each with done_o one cycle after acceptance:
  - DIVU 123/0 → 0xFFFFFFFF.
  - REM 123/0 → 123.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM 0x80000000/0xFFFFFFFF → 0.
- Cancellation and restart:
  - flush_i at the 10th CALC cycle → no done_o; a following DIVU 100/7 returns 14 with full latency.
  - rst pulsed mid-CALC → all outputs 0 asynchronously.
- start_i held high continuously with changing operands → only the op present at each IDLE cycle is accepted; exactly one done_o per accepted op.
